// File: rtl/wb_uart_bridge_if.sv
// ---------------------------------------------------------------------------
// wb_uart_bridge_if
// Classic Wishbone initiator/responder bundle used between the UART debug
// bridge and the SoC bus mux.
//   adr    : bus address (passed through unaligned)
//   dat_w  : write data, initiator -> responder
//   dat_r  : read data, responder -> initiator
//   we     : write enable
//   sel    : byte selects
//   stb    : strobe
//   cyc    : cycle
//   ack    : responder acknowledge
// Modports: master (the bridge side), slave (the responder side).
// ---------------------------------------------------------------------------
interface wb_uart_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 4
);
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          we;
  logic [SW-1:0] sel;
  logic          stb;
  logic          cyc;
  logic          ack;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  dat_r, ack
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output dat_r, ack
  );
endinterface

// File: rtl/wb_uart_bridge.sv
// ---------------------------------------------------------------------------
// wb_uart_bridge
// Byte-stream driven Wishbone initiator for debug/boot loading. A packet is an
// opcode ('W' 0x57 or 'R' 0x52), four address bytes LSB first and, for a
// write, four data bytes LSB first. One classic Wishbone cycle is run and a
// response is streamed back: 'K' for a write, four read bytes LSB first for a
// read, or 'E' when the responder does not ack within TIMEOUT_CYCLES.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-low reset
//   rx_data_i   command byte          rx_valid_i / rx_ready_o handshake
//   tx_data_o   response byte         tx_valid_o / tx_ready_i handshake
//   wb          Wishbone master modport
//   busy_o      high whenever the bridge is not idle
// ---------------------------------------------------------------------------
module wb_uart_bridge #(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_SEL_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  wb_uart_bridge_if.master        wb,
  output logic                    busy_o
);

  localparam logic [7:0]  OP_WRITE = 8'h57;
  localparam logic [7:0]  OP_READ  = 8'h52;
  localparam logic [7:0]  RSP_OK   = 8'h4B;
  localparam logic [7:0]  RSP_ERR  = 8'h45;
  // Counter value at which the next stalled cycle reaches the limit.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t                     state_q;
  logic [1:0]                 cnt_q;
  logic                       is_wr_q;
  logic [WB_ADDR_WIDTH-1:0]   adr_q;
  logic [WB_DATA_WIDTH-1:0]   wdat_q;
  logic [WB_DATA_WIDTH-1:0]   rdat_q;     // remaining read bytes, shifted out LSB first
  logic                       cyc_q;
  logic [WB_SEL_WIDTH-1:0]    sel_q;
  logic [15:0]                tmo_q;
  logic [7:0]                 tx_data_q;
  logic                       tx_valid_q;
  logic                       single_q;   // response is a single status byte
  logic                       rx_ready_q;
  logic                       busy_q;

  logic rx_fire_s;
  logic tx_fire_s;

  assign rx_fire_s = rx_valid_i & rx_ready_q;
  assign tx_fire_s = tx_valid_q & tx_ready_i;

  // Command decode, bus cycle, timeout and response sequencing.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      is_wr_q    <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      cyc_q      <= 1'b0;
      sel_q      <= '0;
      tmo_q      <= 16'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      single_q   <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rx_ready_q <= 1'b1;
          cnt_q      <= 2'd0;
          // Unknown opcodes are consumed and silently dropped.
          if (rx_fire_s && (rx_data_i == OP_WRITE || rx_data_i == OP_READ)) begin
            is_wr_q <= (rx_data_i == OP_WRITE);
            busy_q  <= 1'b1;
            state_q <= S_ADDR;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_ADDR, S_DATA: begin
          if (rx_fire_s) begin
            if (state_q == S_ADDR) begin
              adr_q[cnt_q*8 +: 8] <= rx_data_i;
            end else begin
              wdat_q[cnt_q*8 +: 8] <= rx_data_i;
            end
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (state_q == S_ADDR && is_wr_q) begin
                state_q <= S_DATA;
              end else begin
                state_q    <= S_BUS;
                rx_ready_q <= 1'b0;
                cyc_q      <= 1'b1;
                sel_q      <= '1;
                tmo_q      <= 16'd0;
              end
            end else begin
              state_q <= state_q;
            end
          end else begin
            state_q <= state_q;
          end
        end

        S_BUS: begin
          // Ack is checked first so an ack on the limit cycle still succeeds.
          if (wb.ack) begin
            cyc_q      <= 1'b0;
            sel_q      <= '0;
            tx_valid_q <= 1'b1;
            state_q    <= S_RESP;
            if (is_wr_q) begin
              tx_data_q <= RSP_OK;
              single_q  <= 1'b1;
            end else begin
              tx_data_q <= wb.dat_r[7:0];
              rdat_q    <= {8'h00, wb.dat_r[WB_DATA_WIDTH-1:8]};
              single_q  <= 1'b0;
            end
          end else if (tmo_q == TMO_LAST) begin
            cyc_q      <= 1'b0;
            sel_q      <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= RSP_ERR;
            single_q   <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            tmo_q   <= tmo_q + 16'd1;
            state_q <= S_BUS;
          end
        end

        S_RESP: begin
          if (tx_fire_s) begin
            cnt_q <= cnt_q + 2'd1;
            if (single_q || cnt_q == 2'd3) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              rx_ready_q <= 1'b1;
              cnt_q      <= 2'd0;
              state_q    <= S_IDLE;
            end else begin
              tx_data_q <= rdat_q[7:0];
              rdat_q    <= {8'h00, rdat_q[WB_DATA_WIDTH-1:8]};
              state_q   <= S_RESP;
            end
          end else begin
            state_q <= S_RESP;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          cyc_q      <= 1'b0;
          sel_q      <= '0;
          tx_valid_q <= 1'b0;
          rx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready_o = rx_ready_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign wb.adr     = adr_q;
  assign wb.dat_w   = wdat_q;
  assign wb.we      = cyc_q & is_wr_q;
  assign wb.sel     = sel_q;
  assign wb.stb     = cyc_q;
  assign wb.cyc     = cyc_q;

endmodule

// File: tb/tb_wb_uart_bridge.sv
// ---------------------------------------------------------------------------
// tb_wb_uart_bridge
// Drives command packets into wb_uart_bridge, models a Wishbone responder with
// a programmable ack delay and a byte sink with optional ready toggling, and
// compares bus activity and response bytes against a packet-level model.
// ---------------------------------------------------------------------------
module tb_wb_uart_bridge;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  always #5 clk = ~clk;

  wb_uart_bridge_if bus ();

  wb_uart_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .wb         (bus.master),
    .busy_o     (busy)
  );

  int checks = 0;
  int errors = 0;

  // Responder model: ack in stb cycle number ack_delay (0-based), never if < 0.
  int          ack_delay = -1;
  logic [31:0] slave_rdata = 32'h0;
  int          stb_cycles = 0;
  int          n_bus = 0;
  logic        in_cyc = 1'b0;
  logic [31:0] seen_adr, seen_dat;
  logic        seen_we;

  always @(negedge clk) begin
    if (bus.cyc && bus.stb) begin
      if (!in_cyc) begin
        n_bus++;
        stb_cycles = 0;
        seen_adr = bus.adr;
        seen_dat = bus.dat_w;
        seen_we  = bus.we;
      end
      in_cyc = 1'b1;
      checks++;
      if (bus.sel !== 4'hF) begin
        errors++;
        $display("FAIL sel: got %h expected f", bus.sel);
      end
      bus.ack   = (ack_delay >= 0 && stb_cycles == ack_delay);
      bus.dat_r = bus.ack ? slave_rdata : $urandom;
      stb_cycles++;
    end else begin
      in_cyc  = 1'b0;
      bus.ack = 1'b0;
    end
  end

  // Byte sink with hold-stability checking.
  logic       tx_toggle = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] resp[$];

  always @(negedge clk) begin
    if (tx_toggle) tx_ready = ~tx_ready;
    else tx_ready = 1'b1;
    if (prev_hold && tx_valid) begin
      checks++;
      if (tx_data !== prev_data) begin
        errors++;
        $display("FAIL tx_hold: got %h expected %h", tx_data, prev_data);
      end
    end
    prev_hold = tx_valid && !tx_ready;
    prev_data = tx_data;
    if (tx_valid && tx_ready) resp.push_back(tx_data);
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      errors++;
      $display("FAIL rx_accept: got stalled expected accepted byte %h", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
    send_byte(wr ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'((a >> (8 * i)) & 32'hFF));
    if (wr) for (int i = 0; i < 4; i++) send_byte(8'((d >> (8 * i)) & 32'hFF));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || tx_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
    repeat (3) @(negedge clk);
  endtask

  // One transaction checked against the packet-level model.
  task automatic run_txn(input string name, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd, input int dly,
                         input logic tog);
    logic       ok;
    int         exp_cyc;
    logic [7:0] exp_q[$];
    resp.delete();
    n_bus       = 0;
    ack_delay   = dly;
    slave_rdata = rd;
    tx_toggle   = tog;
    send_cmd(wr, a, d);
    wait_idle();
    ok      = (dly >= 0 && dly < T);
    exp_cyc = ok ? dly + 1 : T;
    if (!ok) exp_q.push_back(8'h45);
    else if (wr) exp_q.push_back(8'h4B);
    else for (int i = 0; i < 4; i++) exp_q.push_back(8'((rd >> (8 * i)) & 32'hFF));
    checks++;
    if (n_bus !== 1) begin errors++; $display("FAIL %s n_bus: got %0d expected 1", name, n_bus); end
    checks++;
    if (stb_cycles !== exp_cyc) begin errors++; $display("FAIL %s stb_cycles: got %0d expected %0d", name, stb_cycles, exp_cyc); end
    checks++;
    if (seen_adr !== a) begin errors++; $display("FAIL %s adr: got %h expected %h", name, seen_adr, a); end
    checks++;
    if (seen_we !== wr) begin errors++; $display("FAIL %s we: got %b expected %b", name, seen_we, wr); end
    if (wr) begin
      checks++;
      if (seen_dat !== d) begin errors++; $display("FAIL %s dat_w: got %h expected %h", name, seen_dat, d); end
    end
    checks++;
    if (resp.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s resp_len: got %0d expected %0d", name, resp.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (resp[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s resp[%0d]: got %h expected %h", name, i, resp[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b expected 0", name, busy); end
    tx_toggle = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cyc, bus.stb, bus.we, tx_valid, busy, rx_ready} !== 6'b0 || bus.adr !== 32'h0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got cyc%b stb%b txv%b busy%b rdy%b adr%h expected all 0",
               bus.cyc, bus.stb, tx_valid, busy, rx_ready, bus.adr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got rdy%b busy%b expected rdy1 busy0", rx_ready, busy);
    end
  endtask

  task automatic test_bad_opcode();
    n_bus = 0;
    send_byte(8'h00);
    repeat (4) @(negedge clk);
    checks++;
    if (n_bus !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_opcode: got n_bus %0d busy %b expected 0 0", n_bus, busy);
    end
    run_txn("after_bad_op", 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0, 1, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    resp.delete();
    ack_delay = -1;
    send_cmd(1'b0, 32'h0000_0040, 32'h0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cyc !== 1'b1) begin errors++; $display("FAIL mid_read_cyc: got %b expected 1", bus.cyc); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cyc, bus.stb, tx_valid, busy} !== 4'b0) begin
      errors++;
      $display("FAIL async_reset: got cyc%b stb%b txv%b busy%b expected 0", bus.cyc, bus.stb, tx_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (resp.size() !== 0) begin errors++; $display("FAIL stale_bytes: got %0d expected 0", resp.size()); end
    run_txn("read_after_reset", 1'b0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    resp.delete();
    n_bus = 0;
    ack_delay = 0;
    slave_rdata = 32'hA1B2_C3D4;
    send_cmd(1'b1, 32'h100, 32'h5555_AAAA);
    send_cmd(1'b0, 32'h104, 32'h0);
    wait_idle();
    checks++;
    if (n_bus !== 2 || resp.size() !== 5) begin
      errors++;
      $display("FAIL b2b_count: got n_bus %0d bytes %0d expected 2 5", n_bus, resp.size());
    end else begin
      checks++;
      if ({resp[0], resp[1], resp[2], resp[3], resp[4]} !== 40'h4B_D4_C3_B2_A1) begin
        errors++;
        $display("FAIL b2b_bytes: got %h %h %h %h %h expected 4b d4 c3 b2 a1",
                 resp[0], resp[1], resp[2], resp[3], resp[4]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      int r = int'($urandom_range(0, 11));
      run_txn("random", 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              (r == 11) ? -1 : r, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    run_txn("write", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 2, 1'b0);
    run_txn("read_toggle", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
    run_txn("read_timeout", 1'b0, 32'h0000_0013, 32'h0, 32'h1111_2222, -1, 1'b0);
    run_txn("write_timeout", 1'b1, 32'h0000_0008, 32'h7, 32'h0, T, 1'b1);
    run_txn("read_ack_on_limit", 1'b0, 32'h0000_0030, 32'h0, 32'h0BAD_F00D, T - 1, 1'b0);
    run_txn("write_ack_on_limit", 1'b1, 32'h0000_0034, 32'h0102_0304, 32'h0, T - 1, 1'b0);
    test_bad_opcode();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
